uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive-side controller behind the UART receiver. Captures each completed character with its error
//  status into an RX FIFO, collects per-character frame/break pulses, and tracks overrun.
//  Raises level and character-timeout interrupts, and gives the register/bus side a first-word-fall-through read port.
// PARAMETERS
//  DEPTH          16   FIFO entries; power of 2, >= 2
//  TIMEOUT_TICKS  160  idle sample_ticks before timeout IRQ (receiver uses 4 ticks/bit, so ~44 ticks/char)
// PORTS
//  clk             in   1      clock
//  resetn          in   1      asynchronous, active-low reset
//  rx_enable       in   1      0: ignore receiver, clear pending errors
//  flush           in   1      1-cycle pulse: empty FIFO, clear pending errors and timeout
//  rx_data_ready   in   1      1-cycle pulse from receiver: character complete
//  rx_data         in   8      receiver data; valid when rx_data_ready=1
//  rx_parity_err   in   1      receiver parity error level; sampled when rx_data_ready=1
//  rx_frame_err    in   1      receiver frame-error pulse (one per stop-bit sample)
//  rx_break_err    in   1      receiver break-error pulse (one per stop-bit sample)
//  sample_tick     in   1      baud sample tick; timebase for timeout
//  threshold       in   $clog2(DEPTH)+1  level IRQ threshold; 0 disables level IRQ
//  rd_en           in   1      pop head entry; ignored when empty
//  rd_data         out  8      head data (FWFT); 0 when empty
//  rd_status       out  3      head status {break,frame,parity}; 0 when empty
//  empty           out  1      FIFO empty
//  full            out  1      FIFO holds DEPTH entries
//  level           out  $clog2(DEPTH)+1  entry count 0..DEPTH
//  overrun         out  1      sticky: character dropped; cleared by ovr_clr or flush
//  ovr_clr         in   1      clear overrun
//  irq_level       out  1      level >= threshold && threshold != 0
//  irq_timeout     out  1      FIFO non-empty and idle for TIMEOUT_TICKS ticks
// BEHAVIOUR
//  Reset: FIFO empty, level=0, empty=1, full=0, overrun=0, pending errors=0, timeout count=0, IRQs=0.
//  Pending errors: pend_frame/pend_break set by rx_*_err pulses while rx_enable=1. They are cleared on a push
//   cycle, flush, or rx_enable=0. A pulse in the push cycle is merged into that character.
//  Push on rx_data_ready && rx_enable && !flush. Entry = {break|pend_break, frame|pend_frame, parity_err, data}.
//   The entry is visible on rd_* the cycle after the push (1-cycle latency empty->valid).
//  Pop on rd_en && !empty. The head advances next cycle.
//  Push+pop in the same cycle: level unchanged. This is also legal when full, and no overrun occurs.
//  Push when full without pop: the new character is dropped, the FIFO is unchanged, and overrun is set next cycle.
//   Pending errors are still cleared.
//  overrun: set has priority over ovr_clr in the same cycle; flush clears overrun.
//  flush has priority over push/pop: level=0 next cycle, and that cycle's rx_data_ready is discarded.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is the explicit counter; full=(level==DEPTH).
//  Timeout counter (saturating at TIMEOUT_TICKS):
//   - reset to 0 on push, pop, flush, or level==0;
//   - otherwise incremented on sample_tick.
//   - irq_timeout=(cnt==TIMEOUT_TICKS)&&!empty, registered.
//  irq_level is registered from the next-state level; both IRQs are levels, not pulses.
//  Mid-operation reset: all state returns to reset values asynchronously; no partial entries survive.
// STRUCTURE
//  uart_pkg: RX_ST_PARITY=0/RX_ST_FRAME=1/RX_ST_BREAK=2 status bit indices, RX_ENTRY_W=11.
//  Sub-module uart_sync_fifo (WIDTH, DEPTH): wr_en/rd_en/din/dout FWFT, level/full/empty.
//  Error accumulation, overrun, timeout and IRQ logic live in uart_rx_ctrl.
// TESTING
//  1. Push 0xA5 with no errors -> next cycle empty=0, rd_data=A5, rd_status=000; rd_en -> empty=1, level=0.
//  2. Frame pulse 2 cycles before data_ready (0x00, parity_err=1) -> head rd_status=011, then pend cleared.
//  3. Fill 16 entries, push 17th -> full=1, overrun=1, head unchanged; ovr_clr -> overrun=0.
//  4. Full and push+pop in the same cycle -> level stays 16, overrun=0, new entry at tail.
//  5. threshold=4, push 4 -> irq_level=1; pop 1 -> irq_level=0.
//  6. One entry, no activity for 160 ticks -> irq_timeout=1. A pop or flush deasserts it next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: status bit positions and RX FIFO entry layout.
package uart_pkg;

  localparam int RX_ST_PARITY = 0;
  localparam int RX_ST_FRAME  = 1;
  localparam int RX_ST_BREAK  = 2;

  localparam int RX_DATA_W  = 8;
  localparam int RX_ST_W    = 3;
  localparam int RX_ENTRY_W = 11;

  typedef logic [RX_ST_W-1:0]    rx_status_t;
  typedef logic [RX_ENTRY_W-1:0] rx_entry_t;

  // Entry layout is {status, data}, so status bit i lands at RX_DATA_W+i.
  function automatic rx_entry_t rx_pack(input logic [RX_DATA_W-1:0] data,
                                        input logic brk,
                                        input logic frm,
                                        input logic par);
    rx_status_t st;
    st = '0;
    st[RX_ST_BREAK]  = brk;
    st[RX_ST_FRAME]  = frm;
    st[RX_ST_PARITY] = par;
    return {st, data};
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with explicit level counter.
// A write while full is accepted only when a read happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LW'(DEPTH));
  assign do_pop  = rd_en && !empty && !clr;
  // When full, the write slot is the head being popped this cycle, so overwriting it is safe.
  assign do_push = wr_en && !clr && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_reg + LW'(do_push) - LW'(do_pop);
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: error accumulation, RX FIFO capture, overrun tracking,
// and level / character-timeout interrupts for the register side.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 160
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     rx_enable,
  input  logic                     flush,
  input  logic                     rx_data_ready,
  input  logic [7:0]               rx_data,
  input  logic                     rx_parity_err,
  input  logic                     rx_frame_err,
  input  logic                     rx_break_err,
  input  logic                     sample_tick,
  input  logic [$clog2(DEPTH):0]   threshold,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [2:0]               rd_status,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic                     irq_level,
  output logic                     irq_timeout
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic          pend_frame_reg, pend_frame_next;
  logic          pend_break_reg, pend_break_next;
  logic          overrun_reg, overrun_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          irq_level_reg, irq_level_next;
  logic          irq_timeout_reg, irq_timeout_next;
  logic [LW-1:0] level_next;

  logic          push_req;
  logic          pop_ok;
  logic          push_ok;
  logic          drop;
  rx_entry_t     wr_entry;
  rx_entry_t     head;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_empty;

  assign push_req = rx_data_ready && rx_enable && !flush;
  assign pop_ok   = rd_en && !flush && !fifo_empty;
  assign push_ok  = push_req && (!fifo_full || pop_ok);
  assign drop     = push_req && fifo_full && !pop_ok;

  // Errors pulsed in the push cycle itself belong to that character.
  assign wr_entry = rx_pack(rx_data,
                            rx_break_err | pend_break_reg,
                            rx_frame_err | pend_frame_reg,
                            rx_parity_err);

  uart_sync_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clr    (flush),
    .wr_en  (push_req),
    .rd_en  (rd_en),
    .din    (wr_entry),
    .dout   (head),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    pend_frame_next  = pend_frame_reg;
    pend_break_next  = pend_break_reg;
    overrun_next     = overrun_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    level_next       = fifo_level;
    irq_level_next   = 1'b0;
    irq_timeout_next = 1'b0;

    if (!rx_enable || flush || push_req) begin
      pend_frame_next = 1'b0;
      pend_break_next = 1'b0;
    end else begin
      if (rx_frame_err) pend_frame_next = 1'b1;
      if (rx_break_err) pend_break_next = 1'b1;
    end

    if (flush) begin
      overrun_next = 1'b0;
    end else if (drop) begin
      overrun_next = 1'b1;
    end else if (ovr_clr) begin
      overrun_next = 1'b0;
    end

    if (flush) begin
      level_next = '0;
    end else begin
      level_next = fifo_level + LW'(push_ok) - LW'(pop_ok);
    end

    if (push_ok || pop_ok || flush || fifo_empty) begin
      tmo_cnt_next = '0;
    end else if (sample_tick && (tmo_cnt_reg < TW'(TIMEOUT_TICKS))) begin
      tmo_cnt_next = tmo_cnt_reg + TW'(1);
    end

    // Both IRQs follow next-state values so a pop or flush drops them one cycle later.
    irq_level_next   = (threshold != '0) && (level_next >= threshold);
    irq_timeout_next = (tmo_cnt_next == TW'(TIMEOUT_TICKS)) && (level_next != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_frame_reg  <= 1'b0;
      pend_break_reg  <= 1'b0;
      overrun_reg     <= 1'b0;
      tmo_cnt_reg     <= '0;
      irq_level_reg   <= 1'b0;
      irq_timeout_reg <= 1'b0;
    end else begin
      pend_frame_reg  <= pend_frame_next;
      pend_break_reg  <= pend_break_next;
      overrun_reg     <= overrun_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      irq_level_reg   <= irq_level_next;
      irq_timeout_reg <= irq_timeout_next;
    end
  end

  assign rd_data     = fifo_empty ? 8'h00 : head[RX_DATA_W-1:0];
  assign rd_status   = fifo_empty ? 3'b000 : head[RX_ENTRY_W-1:RX_DATA_W];
  assign empty       = fifo_empty;
  assign full        = fifo_full;
  assign level       = fifo_level;
  assign overrun     = overrun_reg;
  assign irq_level   = irq_level_reg;
  assign irq_timeout = irq_timeout_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: FIFO capture, error merging, overrun, flush, IRQs and async reset.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_enable;
  logic       flush;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_break_err;
  logic       sample_tick;
  logic [4:0] threshold;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [2:0] rd_status;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       overrun;
  logic       ovr_clr;
  logic       irq_level;
  logic       irq_timeout;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(16), .TIMEOUT_TICKS(160)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .rx_enable     (rx_enable),
    .flush         (flush),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_break_err  (rx_break_err),
    .sample_tick   (sample_tick),
    .threshold     (threshold),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_status     (rd_status),
    .empty         (empty),
    .full          (full),
    .level         (level),
    .overrun       (overrun),
    .ovr_clr       (ovr_clr),
    .irq_level     (irq_level),
    .irq_timeout   (irq_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic par, input logic frm, input logic brk);
    rx_data_ready = 1'b1;
    rx_data       = d;
    rx_parity_err = par;
    rx_frame_err  = frm;
    rx_break_err  = brk;
    step();
    rx_data_ready = 1'b0;
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
    rx_break_err  = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; rx_enable = 1'b0; flush = 1'b0; rx_data_ready = 1'b0;
    rx_data = 8'h00; rx_parity_err = 1'b0; rx_frame_err = 1'b0; rx_break_err = 1'b0;
    sample_tick = 1'b0; threshold = 5'd0; rd_en = 1'b0; ovr_clr = 1'b0;
    step(); step();

    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_irqs", 32'({irq_level, irq_timeout}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    resetn = 1'b1;
    rx_enable = 1'b1;
    step();

    // Basic push / pop
    push(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_data", 32'(rd_data), 32'hA5);
    chk("t1_status", 32'(rd_status), 32'b000);
    chk("t1_level", 32'(level), 32'd1);
    pop();
    chk("t1_pop_empty", 32'(empty), 32'd1);
    chk("t1_pop_level", 32'(level), 32'd0);
    chk("t1_pop_data", 32'(rd_data), 32'h00);

    // Frame pulse two cycles ahead of a character with parity error
    rx_frame_err = 1'b1; step(); rx_frame_err = 1'b0; step();
    push(8'h00, 1'b1, 1'b0, 1'b0);
    push(8'h11, 1'b0, 1'b0, 1'b0);
    chk("t2_status", 32'(rd_status), 32'b011);
    chk("t2_data", 32'(rd_data), 32'h00);
    pop();
    chk("t2_clr_status", 32'(rd_status), 32'b000);
    chk("t2_clr_data", 32'(rd_data), 32'h11);
    pop();

    // Break pulse in the push cycle merges into that character
    push(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("brk_merge_status", 32'(rd_status), 32'b100);
    pop();

    // rx_enable low clears a pending frame error
    rx_frame_err = 1'b1; step(); rx_frame_err = 1'b0;
    rx_enable = 1'b0; step(); rx_enable = 1'b1;
    push(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("en_clr_status", 32'(rd_status), 32'b000);
    pop();

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_ovr_pre", 32'(overrun), 32'd0);
    push(8'hEE, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr", 32'(overrun), 32'd1);
    chk("t3_lvl_ovr", 32'(level), 32'd16);
    chk("t3_head", 32'(rd_data), 32'h10);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("t3_ovr_clr", 32'(overrun), 32'd0);
    // Set beats clear in the same cycle
    ovr_clr = 1'b1; push(8'hEF, 1'b0, 1'b0, 1'b0); ovr_clr = 1'b0;
    chk("t3_set_prio", 32'(overrun), 32'd1);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("t3_ovr_clr2", 32'(overrun), 32'd0);

    // Full with simultaneous push and pop
    rd_en = 1'b1; push(8'h77, 1'b0, 1'b0, 1'b0); rd_en = 1'b0;
    chk("t4_level", 32'(level), 32'd16);
    chk("t4_ovr", 32'(overrun), 32'd0);
    chk("t4_head", 32'(rd_data), 32'h11);
    for (int i = 0; i < 15; i++) pop();
    chk("t4_tail", 32'(rd_data), 32'h77);
    chk("t4_tail_lvl", 32'(level), 32'd1);

    // Flush discards the same-cycle character
    flush = 1'b1; push(8'h99, 1'b0, 1'b0, 1'b0); flush = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    push(8'h42, 1'b0, 1'b0, 1'b0);
    chk("flush_after", 32'(rd_data), 32'h42);
    chk("flush_after_lvl", 32'(level), 32'd1);
    do_flush();

    // Level interrupt
    threshold = 5'd4;
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    chk("t5_irq_3", 32'(irq_level), 32'd0);
    push(8'h63, 1'b0, 1'b0, 1'b0);
    chk("t5_irq_4", 32'(irq_level), 32'd1);
    pop();
    chk("t5_irq_pop", 32'(irq_level), 32'd0);
    threshold = 5'd0;
    do_flush();

    // Character timeout, cleared by pop
    sample_tick = 1'b1;
    push(8'h81, 1'b0, 1'b0, 1'b0);
    repeat (159) step();
    chk("t6_tmo_159", 32'(irq_timeout), 32'd0);
    step();
    chk("t6_tmo_160", 32'(irq_timeout), 32'd1);
    repeat (5) step();
    chk("t6_tmo_sat", 32'(irq_timeout), 32'd1);
    pop();
    chk("t6_tmo_pop", 32'(irq_timeout), 32'd0);

    // Character timeout, cleared by flush
    push(8'h82, 1'b0, 1'b0, 1'b0);
    repeat (160) step();
    chk("t6_tmo_again", 32'(irq_timeout), 32'd1);
    do_flush();
    chk("t6_tmo_flush", 32'(irq_timeout), 32'd0);
    sample_tick = 1'b0;

    // Asynchronous reset mid-operation
    push(8'hC1, 1'b0, 1'b0, 1'b0);
    push(8'hC2, 1'b0, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_level", 32'(level), 32'd0);
    step();
    resetn = 1'b1;
    step();
    push(8'hD7, 1'b0, 1'b0, 1'b0);
    chk("arst_push_data", 32'(rd_data), 32'hD7);
    chk("arst_push_lvl", 32'(level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
